bcd_down_timer: RTL and testbench
=================================

Name: bcd_down_timer

Overview:
Parametrised multi-digit BCD down-counter for the microwave cook timer. It generalises the single mod-10 digit into a DIGITS-wide cascaded chain with optional sexagesimal (MM:SS) tens digits. It adds a run/pause/done state machine with a one-cycle done pulse. It sits between the keypad/load logic and the display driver, and advances on an external one-per-second tick enable.

Parameters:
DIGITS, 4, number of BCD digits (>=2); digit 0 is least significant.
SEXAGESIMAL, 1, when 1, odd-index digits (1, 3, ...) count mod 6; all other digits count mod 10. When 0, every digit counts mod 10.

Ports:
clk  input  1  system clock, all state changes on rising edge
clrn  input  1  reset, synchronous, active-low
data  input  4*DIGITS  load value, digit i at bits [4i+3:4i]
loadn  input  1  active-low synchronous load request
start  input  1  start/resume request (level, sampled per cycle)
pause  input  1  pause request (level, sampled per cycle)
tick  input  1  one-cycle count enable (1 Hz strobe)
out  output  4*DIGITS  current count, BCD per digit
zero  output  1  high when out is all zeros
done  output  1  one-cycle pulse on reaching zero while running
running  output  1  high in RUN state
state  output  2  IDLE=0, RUN=1, PAUSE=2, DONE=3

Behaviour:
- Single clock domain, clk. Reset is synchronous and active-low, named clrn. All other controls are synchronous.
- Reset (clrn=0 at an edge): out=0, state=IDLE, done=0, running=0, zero=1. Reset overrides everything, including mid-run.
- Priority per edge: clrn > loadn > pause > start > tick.
- Load (loadn=0): accepted in IDLE, PAUSE and DONE; ignored in RUN.
  - On accept: out<=data, state<=IDLE.
  - Each loaded digit saturates to its max if out of range: mod-10 digit >9 becomes 9; mod-6 digit >5 becomes 5.
- IDLE:
  - start=1 and out!=0 -> RUN.
  - start=1 and out==0 -> stay IDLE.
- RUN:
  - pause=1 -> PAUSE; a tick in the same cycle is dropped.
  - Otherwise, tick=1 decrements out by one step.
- PAUSE: out frozen; ticks ignored; start=1 (with pause=0) -> RUN.
- Decrement rule (RUN, tick=1):
  - Digit 0 always steps.
  - Digit i steps only if digits 0..i-1 are all zero before the tick (borrow chain).
  - A stepping digit at 0 wraps to its max (9 or 5); otherwise it decrements by 1.
  - Example, SEXAGESIMAL=1: 01:00 -> 00:59; 10:00 -> 09:59.
- Terminal: when a tick takes out to all zeros, out<=0 and state<=DONE on that edge. done=1 for exactly the following cycle, then 0. No wrap from 00:00 ever occurs in RUN.
- DONE: out held at 0; start ignored; leaves DONE only via load (-> IDLE) or reset.
- Output timing:
  - zero is combinational from out.
  - running is combinational from state (state==RUN).
  - done is registered.
  - Latency tick -> out change: 1 clock.
- tick held high for several cycles decrements once per cycle; the source must strobe.

Test Plan:
- Reset, load data=0x0130 (01:30), start, apply 90 ticks -> out passes 0x0100, 0x0059 ... 0x0000. state=DONE after the 90th tick; done high exactly one cycle; zero=1.
- Load 0x1000, start, 1 tick -> out=0x0959. With SEXAGESIMAL=0, same stimulus -> out=0x0999.
- Load 0x7FAF -> out=0x5959 (SEXAGESIMAL=1) or 0x7999 (SEXAGESIMAL=0). Then loadn=0 with data=0x0005 during RUN -> ignored, out keeps decrementing.
- Load 0x0005, start, 2 ticks (out=0x0003), pause with tick in the same cycle -> out stays 0x0003, state=PAUSE. 10 ticks -> unchanged. start, 3 ticks -> DONE.
- Load 0x0000, start -> state stays IDLE, done never asserts. Load 0x0002, start, 1 tick, clrn=0 -> out=0, state=IDLE, running=0 on the next edge.
- pause and start both high in RUN -> PAUSE. loadn=0 and start=1 in IDLE -> load only, state IDLE. start=1 in DONE -> no change.

Source files
------------

// File: rtl/bcd_down_timer_if.sv
// Control/data bundle between the keypad/load logic (master) and the cook timer (slave).
// Clock and reset stay outside as plain ports.
interface bcd_down_timer_if #(
  parameter int DIGITS = 4
);
  logic [4*DIGITS-1:0] data;
  logic                loadn;
  logic                start;
  logic                pause;
  logic                tick;
  logic [4*DIGITS-1:0] out;
  logic                zero;
  logic                done;
  logic                running;
  logic [1:0]          state;

  modport master (
    output data, loadn, start, pause, tick,
    input  out, zero, done, running, state
  );

  modport slave (
    input  data, loadn, start, pause, tick,
    output out, zero, done, running, state
  );
endinterface

// File: rtl/bcd_down_timer.sv
// Cascaded BCD down-counter for the cook timer with run/pause/done control.
// Odd-index digits count mod 6 when SEXAGESIMAL is set (MM:SS display).
//
//   state | meaning
//   IDLE  | loaded or reset, waiting for start with a nonzero count
//   RUN   | decrementing one step per tick
//   PAUSE | count frozen, start resumes
//   DONE  | count reached zero while running, only load or reset leaves
module bcd_down_timer #(
  parameter int DIGITS      = 4,
  parameter int SEXAGESIMAL = 1
) (
  input logic              clk,
  input logic              clrn,
  bcd_down_timer_if.slave  bus
);
  localparam int W = 4 * DIGITS;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    PAUSE = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t         state_q;
  logic [W-1:0]   cnt_q;
  logic           done_q;

  logic [W-1:0]      load_d;
  logic [W-1:0]      dec_d;
  logic [DIGITS-1:0] borrow;
  logic              cnt_zero;
  logic              dec_zero;

  function automatic logic [3:0] digit_max(input int idx);
    return ((SEXAGESIMAL != 0) && (idx % 2 == 1)) ? 4'd5 : 4'd9;
  endfunction

  // borrow[i]: every digit below i is zero, so digit i steps on this tick
  always_comb begin
    borrow    = '0;
    borrow[0] = 1'b1;
    for (int i = 1; i < DIGITS; i++) begin
      borrow[i] = borrow[i-1] & (cnt_q[4*(i-1) +: 4] == 4'd0);
    end
  end

  always_comb begin
    load_d = '0;
    dec_d  = '0;
    for (int i = 0; i < DIGITS; i++) begin
      if (bus.data[4*i +: 4] > digit_max(i)) begin
        load_d[4*i +: 4] = digit_max(i);
      end else begin
        load_d[4*i +: 4] = bus.data[4*i +: 4];
      end

      if (!borrow[i]) begin
        dec_d[4*i +: 4] = cnt_q[4*i +: 4];
      end else if (cnt_q[4*i +: 4] == 4'd0) begin
        dec_d[4*i +: 4] = digit_max(i);
      end else begin
        dec_d[4*i +: 4] = cnt_q[4*i +: 4] - 4'd1;
      end
    end
  end

  assign cnt_zero = (cnt_q == '0);
  assign dec_zero = (dec_d == '0);

  always_ff @(posedge clk) begin
    if (!clrn) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      done_q  <= 1'b0;
    end else begin
      done_q <= 1'b0;
      if (!bus.loadn && (state_q != RUN)) begin
        cnt_q   <= load_d;
        state_q <= IDLE;
      end else begin
        case (state_q)
          IDLE: begin
            if (bus.start && !cnt_zero) begin
              state_q <= RUN;
            end
          end
          RUN: begin
            // pause outranks tick, so a coincident tick is dropped
            if (bus.pause) begin
              state_q <= PAUSE;
            end else if (bus.tick) begin
              cnt_q <= dec_d;
              if (dec_zero) begin
                state_q <= DONE;
                done_q  <= 1'b1;
              end
            end
          end
          PAUSE: begin
            if (!bus.pause && bus.start) begin
              state_q <= RUN;
            end
          end
          DONE: begin
            state_q <= DONE;
          end
          default: begin
            state_q <= IDLE;
          end
        endcase
      end
    end
  end

  assign bus.out     = cnt_q;
  assign bus.zero    = cnt_zero;
  assign bus.done    = done_q;
  assign bus.running = (state_q == RUN);
  assign bus.state   = state_q;
endmodule

// File: tb/tb_bcd_down_timer.sv
// Bench for bcd_down_timer: MM:SS and all-decimal instances driven in lockstep,
// vector table plus a full 01:30 countdown checked against a seconds model.
module tb_bcd_down_timer;
  logic clk;
  logic clrn;

  bcd_down_timer_if #(.DIGITS(4)) if6 ();
  bcd_down_timer_if #(.DIGITS(4)) if10 ();

  bcd_down_timer #(.DIGITS(4), .SEXAGESIMAL(1)) dut6 (
    .clk  (clk),
    .clrn (clrn),
    .bus  (if6.slave)
  );

  bcd_down_timer #(.DIGITS(4), .SEXAGESIMAL(0)) dut10 (
    .clk  (clk),
    .clrn (clrn),
    .bus  (if10.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        clrn;
    logic        loadn;
    logic        start;
    logic        pause;
    logic        tick;
    logic [15:0] data;
    logic [15:0] exp_out;
    logic [1:0]  exp_state;
    logic        exp_done;
    logic        chk10;
    logic [15:0] exp_out10;
  } vec_t;

  localparam logic [1:0] S_IDLE = 2'd0, S_RUN = 2'd1, S_PAUSE = 2'd2, S_DONE = 2'd3;

  vec_t vecs[$];
  vec_t sb[$];
  int   total = 0;
  int   bad   = 0;
  int   step  = 0;

  function automatic vec_t mk(logic c, logic l, logic s, logic p, logic t, logic [15:0] d,
                              logic [15:0] eo, logic [1:0] es, logic ed, logic c10,
                              logic [15:0] eo10);
    vec_t v;
    v.clrn = c; v.loadn = l; v.start = s; v.pause = p; v.tick = t; v.data = d;
    v.exp_out = eo; v.exp_state = es; v.exp_done = ed; v.chk10 = c10; v.exp_out10 = eo10;
    return v;
  endfunction

  function automatic logic [15:0] mmss(int secs);
    int m;
    int s;
    m = secs / 60;
    s = secs % 60;
    return {4'(m / 10), 4'(m % 10), 4'(s / 10), 4'(s % 10)};
  endfunction

  function automatic logic [15:0] dec4(int n);
    return {4'(n / 1000), 4'((n / 100) % 10), 4'((n / 10) % 10), 4'(n % 10)};
  endfunction

  task automatic cmp(string nm, logic [15:0] act, logic [15:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL step%0d %s got=%h exp=%h", step, nm, act, exp);
    end
  endtask

  task automatic check_pop();
    vec_t e;
    if (sb.size() == 0) begin
      total++;
      bad++;
      $display("FAIL step%0d scoreboard got=empty exp=entry", step);
      return;
    end
    e = sb.pop_front();
    cmp("out",     if6.out, e.exp_out);
    cmp("state",   16'(if6.state), 16'(e.exp_state));
    cmp("done",    16'(if6.done), 16'(e.exp_done));
    cmp("zero",    16'(if6.zero), 16'(e.exp_out == 16'h0000));
    cmp("running", 16'(if6.running), 16'(e.exp_state == S_RUN));
    if (e.chk10) begin
      cmp("out10",  if10.out, e.exp_out10);
      cmp("zero10", 16'(if10.zero), 16'(e.exp_out10 == 16'h0000));
    end
  endtask

  task automatic apply(vec_t v);
    @(negedge clk);
    clrn       = v.clrn;
    if6.loadn  = v.loadn;  if10.loadn = v.loadn;
    if6.start  = v.start;  if10.start = v.start;
    if6.pause  = v.pause;  if10.pause = v.pause;
    if6.tick   = v.tick;   if10.tick  = v.tick;
    if6.data   = v.data;   if10.data  = v.data;
    sb.push_back(v);
    @(posedge clk);
    #1;
    step++;
    check_pop();
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    clrn = 1'b0;
    if6.loadn = 1'b1; if6.start = 1'b0; if6.pause = 1'b0; if6.tick = 1'b0; if6.data = '0;
    if10.loadn = 1'b1; if10.start = 1'b0; if10.pause = 1'b0; if10.tick = 1'b0; if10.data = '0;

    //              clrn ld st pa tk data       out       state    dn c10 out10
    vecs.push_back(mk(0, 1, 0, 0, 0, 16'h0000, 16'h0000, S_IDLE,  0, 1, 16'h0000));
    vecs.push_back(mk(1, 0, 0, 0, 0, 16'h1000, 16'h1000, S_IDLE,  0, 1, 16'h1000));
    vecs.push_back(mk(1, 1, 1, 0, 0, 16'h0000, 16'h1000, S_RUN,   0, 1, 16'h1000));
    vecs.push_back(mk(1, 1, 0, 0, 1, 16'h0000, 16'h0959, S_RUN,   0, 1, 16'h0999));
    vecs.push_back(mk(1, 1, 0, 1, 0, 16'h0000, 16'h0959, S_PAUSE, 0, 1, 16'h0999));
    vecs.push_back(mk(1, 0, 0, 0, 0, 16'h7FAF, 16'h5959, S_IDLE,  0, 1, 16'h7999));
    vecs.push_back(mk(1, 1, 1, 0, 0, 16'h0000, 16'h5959, S_RUN,   0, 1, 16'h7999));
    vecs.push_back(mk(1, 0, 0, 0, 1, 16'h0005, 16'h5958, S_RUN,   0, 1, 16'h7998));
    vecs.push_back(mk(1, 1, 0, 0, 1, 16'h0000, 16'h5957, S_RUN,   0, 1, 16'h7997));
    vecs.push_back(mk(1, 1, 1, 1, 1, 16'h0000, 16'h5957, S_PAUSE, 0, 1, 16'h7997));
    vecs.push_back(mk(1, 1, 0, 0, 1, 16'h0000, 16'h5957, S_PAUSE, 0, 1, 16'h7997));
    vecs.push_back(mk(1, 1, 1, 0, 0, 16'h0000, 16'h5957, S_RUN,   0, 1, 16'h7997));
    vecs.push_back(mk(1, 1, 0, 1, 0, 16'h0000, 16'h5957, S_PAUSE, 0, 1, 16'h7997));
    vecs.push_back(mk(1, 0, 0, 0, 0, 16'h0005, 16'h0005, S_IDLE,  0, 1, 16'h0005));
    vecs.push_back(mk(1, 1, 1, 0, 0, 16'h0000, 16'h0005, S_RUN,   0, 1, 16'h0005));
    vecs.push_back(mk(1, 1, 0, 0, 1, 16'h0000, 16'h0004, S_RUN,   0, 1, 16'h0004));
    vecs.push_back(mk(1, 1, 0, 0, 1, 16'h0000, 16'h0003, S_RUN,   0, 1, 16'h0003));
    vecs.push_back(mk(1, 1, 0, 1, 1, 16'h0000, 16'h0003, S_PAUSE, 0, 1, 16'h0003));
    for (int i = 0; i < 10; i++)
      vecs.push_back(mk(1, 1, 0, 0, 1, 16'h0000, 16'h0003, S_PAUSE, 0, 1, 16'h0003));
    vecs.push_back(mk(1, 1, 1, 0, 0, 16'h0000, 16'h0003, S_RUN,   0, 1, 16'h0003));
    vecs.push_back(mk(1, 1, 0, 0, 1, 16'h0000, 16'h0002, S_RUN,   0, 1, 16'h0002));
    vecs.push_back(mk(1, 1, 0, 0, 1, 16'h0000, 16'h0001, S_RUN,   0, 1, 16'h0001));
    vecs.push_back(mk(1, 1, 0, 0, 1, 16'h0000, 16'h0000, S_DONE,  1, 1, 16'h0000));
    vecs.push_back(mk(1, 1, 0, 0, 0, 16'h0000, 16'h0000, S_DONE,  0, 1, 16'h0000));
    vecs.push_back(mk(1, 1, 1, 0, 0, 16'h0000, 16'h0000, S_DONE,  0, 1, 16'h0000));
    vecs.push_back(mk(1, 1, 0, 0, 1, 16'h0000, 16'h0000, S_DONE,  0, 1, 16'h0000));
    vecs.push_back(mk(1, 0, 1, 0, 0, 16'h0000, 16'h0000, S_IDLE,  0, 1, 16'h0000));
    vecs.push_back(mk(1, 1, 1, 0, 0, 16'h0000, 16'h0000, S_IDLE,  0, 1, 16'h0000));
    vecs.push_back(mk(1, 1, 1, 0, 1, 16'h0000, 16'h0000, S_IDLE,  0, 1, 16'h0000));
    vecs.push_back(mk(1, 0, 0, 0, 0, 16'h0002, 16'h0002, S_IDLE,  0, 1, 16'h0002));
    vecs.push_back(mk(1, 1, 1, 0, 0, 16'h0000, 16'h0002, S_RUN,   0, 1, 16'h0002));
    vecs.push_back(mk(1, 1, 0, 0, 1, 16'h0000, 16'h0001, S_RUN,   0, 1, 16'h0001));
    vecs.push_back(mk(0, 1, 1, 0, 1, 16'h0000, 16'h0000, S_IDLE,  0, 1, 16'h0000));
    vecs.push_back(mk(1, 0, 1, 0, 0, 16'h0130, 16'h0130, S_IDLE,  0, 1, 16'h0130));

    foreach (vecs[i]) apply(vecs[i]);

    // 01:30 countdown; the decimal instance holds 130 and is still running at the end
    apply(mk(1, 1, 1, 0, 0, 16'h0000, 16'h0130, S_RUN, 0, 1, 16'h0130));
    for (int k = 1; k <= 90; k++) begin
      apply(mk(1, 1, 0, 0, 1, 16'h0000, mmss(90 - k), (k == 90) ? S_DONE : S_RUN,
               (k == 90) ? 1'b1 : 1'b0, 1, dec4(130 - k)));
    end
    apply(mk(1, 1, 0, 0, 0, 16'h0000, 16'h0000, S_DONE, 0, 1, 16'h0040));
    apply(mk(1, 1, 0, 0, 0, 16'h0000, 16'h0000, S_DONE, 0, 1, 16'h0040));

    total++;
    if (sb.size() != 0) begin
      bad++;
      $display("FAIL scoreboard_drain got=%0d exp=0", sb.size());
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
